// File: rtl/uniboard_bus_pkg.sv
// Shared widths, bus direction encodings and sequencer state type for the
// internal peripheral bus.
package uniboard_bus_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned REGADDR_W = 8;
    localparam int unsigned SIZE_W    = 3;
    localparam int unsigned SEL_W     = 128;
    localparam int unsigned IDX_W     = 7;

    localparam logic BUS_WRITE = 1'b0;
    localparam logic BUS_READ  = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StStrobe,
        StHold,
        StResp
    } bus_state_t;

    // Largest of the three phase lengths; sizes the shared phase counter.
    function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/periph_bus_sequencer_if.sv
// Command / response handshake between the protocol FSM (master) and the
// bus sequencer (slave).
interface periph_bus_sequencer_if;
    import uniboard_bus_pkg::*;

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [IDX_W-1:0]     cmd_periph;
    logic [REGADDR_W-1:0] cmd_reg;
    logic                 cmd_rw;
    logic [DATA_W-1:0]    cmd_wdata;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [DATA_W-1:0]    rsp_rdata;
    logic [SIZE_W-1:0]    rsp_size;
    logic                 rsp_error;

    modport master (
        output cmd_valid, cmd_periph, cmd_reg, cmd_rw, cmd_wdata, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_size, rsp_error
    );

    modport slave (
        input  cmd_valid, cmd_periph, cmd_reg, cmd_rw, cmd_wdata, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_size, rsp_error
    );

endinterface

// File: rtl/bus_select_decoder.sv
// Index + strobe to one-hot select; unimplemented indices select nothing.
module bus_select_decoder
    import uniboard_bus_pkg::*;
#(
    parameter int unsigned NUM_PERIPH = 128
) (
    input  logic [IDX_W-1:0] i_index,
    input  logic             i_strobe,
    output logic [SEL_W-1:0] o_select
);

    // At most one line high, and only while strobing a valid index.
    always_comb begin
        o_select = '0;
        if (i_strobe && ({1'b0, i_index} < 8'(NUM_PERIPH))) begin
            o_select[i_index] = 1'b1;
        end
    end

endmodule

// File: rtl/periph_bus_sequencer.sv
// Runs one peripheral bus transaction per accepted command:
// setup -> select strobe -> hold -> response.
module periph_bus_sequencer
    import uniboard_bus_pkg::*;
#(
    parameter int unsigned NUM_PERIPH    = 128,
    parameter int unsigned SETUP_CYCLES  = 1,
    parameter int unsigned STROBE_CYCLES = 2,
    parameter int unsigned HOLD_CYCLES   = 1
) (
    input  logic                 clk_12MHz,
    input  logic                 reset,
    periph_bus_sequencer_if.slave bus_if,
    output logic [REGADDR_W-1:0] register_addr,
    output logic                 rw,
    output logic [SEL_W-1:0]     select,
    inout  wire  [DATA_W-1:0]    databus,
    input  logic [SIZE_W-1:0]    reg_size
);

    localparam int unsigned MaxPh = max3(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES);
    localparam int unsigned CntW  = $clog2(MaxPh + 1);

    bus_state_t           r_state, w_state_nxt;
    logic [CntW-1:0]      r_cnt, w_cnt_nxt;
    logic [IDX_W-1:0]     r_periph;
    logic [REGADDR_W-1:0] r_reg_addr;
    logic                 r_rw;
    logic [DATA_W-1:0]    r_wdata;
    logic [DATA_W-1:0]    r_rdata;
    logic [SIZE_W-1:0]    r_size;
    logic                 r_error;

    logic w_accept, w_bad, w_active, w_capture, w_cnt_zero;

    assign w_accept   = bus_if.cmd_valid && bus_if.cmd_ready;
    assign w_bad      = ({1'b0, bus_if.cmd_periph} >= 8'(NUM_PERIPH));
    assign w_active   = (r_state == StSetup) || (r_state == StStrobe) || (r_state == StHold);
    assign w_cnt_zero = (r_cnt == '0);
    assign w_capture  = (r_state == StStrobe) && w_cnt_zero && (r_rw == BUS_READ);

    // State and phase counter; async reset drops select/databus immediately.
    always_ff @(posedge clk_12MHz or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state: each phase loads its length-1 and counts down to zero.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    if (w_bad) begin
                        w_state_nxt = StResp;
                    end else begin
                        w_state_nxt = StSetup;
                        w_cnt_nxt   = CntW'(SETUP_CYCLES - 1);
                    end
                end
            end
            StSetup: begin
                if (w_cnt_zero) begin
                    w_state_nxt = StStrobe;
                    w_cnt_nxt   = CntW'(STROBE_CYCLES - 1);
                end else begin
                    w_cnt_nxt = r_cnt - CntW'(1);
                end
            end
            StStrobe: begin
                if (w_cnt_zero) begin
                    w_state_nxt = StHold;
                    w_cnt_nxt   = CntW'(HOLD_CYCLES - 1);
                end else begin
                    w_cnt_nxt = r_cnt - CntW'(1);
                end
            end
            StHold: begin
                if (w_cnt_zero) begin
                    w_state_nxt = StResp;
                end else begin
                    w_cnt_nxt = r_cnt - CntW'(1);
                end
            end
            StResp: begin
                if (bus_if.rsp_ready) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // Command latch and read capture; response fields clear on every accept.
    always_ff @(posedge clk_12MHz or posedge reset) begin
        if (reset) begin
            r_periph   <= '0;
            r_reg_addr <= '0;
            r_rw       <= BUS_READ;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_size     <= '0;
            r_error    <= 1'b0;
        end else if (w_accept) begin
            r_periph <= bus_if.cmd_periph;
            r_rw     <= bus_if.cmd_rw;
            r_wdata  <= bus_if.cmd_wdata;
            r_rdata  <= '0;
            r_size   <= '0;
            r_error  <= w_bad;
            // Rejected commands leave the bus address untouched.
            if (!w_bad) begin
                r_reg_addr <= bus_if.cmd_reg;
            end
        end else if (w_capture) begin
            r_rdata <= databus;
            r_size  <= reg_size;
        end
    end

    bus_select_decoder #(
        .NUM_PERIPH (NUM_PERIPH)
    ) u_decoder (
        .i_index  (r_periph),
        .i_strobe (r_state == StStrobe),
        .o_select (select)
    );

    assign register_addr = r_reg_addr;
    assign rw            = w_active ? r_rw : BUS_READ;
    assign databus       = (w_active && (r_rw == BUS_WRITE)) ? r_wdata : 'z;

    assign bus_if.cmd_ready = (r_state == StIdle) && !reset;
    assign bus_if.rsp_valid = (r_state == StResp);
    assign bus_if.rsp_rdata = r_rdata;
    assign bus_if.rsp_size  = r_size;
    assign bus_if.rsp_error = r_error;

endmodule

// File: tb/tb_periph_bus_sequencer.sv
// Directed bench: three sequencer instances (defaults, NUM_PERIPH=16,
// S/T/H=3/1/2) driven one at a time; responses checked against a queue.
module tb_periph_bus_sequencer;

    typedef struct packed {
        logic [31:0] rdata;
        logic [2:0]  size;
        logic        err;
    } rsp_t;

    typedef struct packed {
        logic         valid;
        logic         ready;
        logic         err;
        logic         rw;
        logic [31:0]  rdata;
        logic [2:0]   size;
        logic [127:0] sel;
        logic [7:0]   ra;
        logic [31:0]  bus;
    } obs_t;

    localparam logic [31:0] IdleVal = 32'h5A5A5A5A;

    logic        clk = 1'b0;
    logic        rst;
    logic        t_valid, t_rsp_ready, t_rw, t_drv;
    logic [6:0]  t_periph;
    logic [7:0]  t_reg;
    logic [31:0] t_wdata, t_rd_val;
    logic [2:0]  t_size;
    int          cur;
    logic [127:0] exp_sel;
    rsp_t        exp_q[$];
    obs_t        obs[3];
    obs_t        m;
    int          n_cmp = 0;
    int          n_mis = 0;

    always #5 clk = ~clk;

    periph_bus_sequencer_if ifs[3] ();

    for (genvar k = 0; k < 3; k++) begin : g_dut
        wire  [31:0]  bus;
        logic [127:0] sel;
        logic [7:0]   ra;
        logic         rw_o;
        logic [2:0]   rs;

        periph_bus_sequencer #(
            .NUM_PERIPH    ((k == 1) ? 16 : 128),
            .SETUP_CYCLES  ((k == 2) ? 3 : 1),
            .STROBE_CYCLES ((k == 2) ? 1 : 2),
            .HOLD_CYCLES   ((k == 2) ? 2 : 1)
        ) u_dut (
            .clk_12MHz     (clk),
            .reset         (rst),
            .bus_if        (ifs[k]),
            .register_addr (ra),
            .rw            (rw_o),
            .select        (sel),
            .databus       (bus),
            .reg_size      (rs)
        );

        // Peripheral model: returns read data only while selected.
        assign bus = (t_drv && cur == k) ? ((|sel) ? t_rd_val : IdleVal) : 'z;
        assign rs  = (|sel) ? t_size : 3'd5;

        assign ifs[k].cmd_valid  = t_valid && (cur == k);
        assign ifs[k].cmd_periph = t_periph;
        assign ifs[k].cmd_reg    = t_reg;
        assign ifs[k].cmd_rw     = t_rw;
        assign ifs[k].cmd_wdata  = t_wdata;
        assign ifs[k].rsp_ready  = t_rsp_ready && (cur == k);

        assign obs[k] = '{valid: ifs[k].rsp_valid, ready: ifs[k].cmd_ready,
                          err: ifs[k].rsp_error, rw: rw_o, rdata: ifs[k].rsp_rdata,
                          size: ifs[k].rsp_size, sel: sel, ra: ra, bus: bus};
    end

    always_comb begin
        m = obs[0];
        if (cur == 1) m = obs[1];
        else if (cur == 2) m = obs[2];
    end

    task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic issue(input logic [6:0] p, input logic [7:0] r, input logic w,
                         input logic [31:0] d);
        int num;
        num = (cur == 1) ? 16 : 128;
        @(posedge clk); #1;
        t_periph = p; t_reg = r; t_rw = w; t_wdata = d; t_valid = 1'b1;
        exp_sel  = (int'(p) < num) ? (128'd1 << p) : '0;
        @(negedge clk);
        chk("accept_ready", m.ready, 1);
        @(posedge clk); #1;
        t_valid = 1'b0;
    endtask

    task automatic push(input logic [31:0] rd, input logic [2:0] sz, input logic er);
        exp_q.push_back('{rdata: rd, size: sz, err: er});
    endtask

    task automatic wait_rsp(input int max_cyc, output int n, output int hi);
        n = 0; hi = 0;
        do begin
            @(negedge clk);
            n++;
            if (m.sel != '0) begin
                hi++;
                chk("select_onehot", m.sel, exp_sel);
            end
            if (!m.valid) chk("busy_cmd_ready", m.ready, 0);
        end while (!m.valid && n < max_cyc);
        chk("rsp_valid_seen", m.valid, 1);
    endtask

    task automatic check_rsp();
        rsp_t e;
        chk("sb_nonempty", 128'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("rsp_rdata", m.rdata, e.rdata);
            chk("rsp_size", m.size, e.size);
            chk("rsp_error", m.err, e.err);
        end
    endtask

    task automatic ack();
        t_rsp_ready = 1'b1;
        @(posedge clk); #1;
        t_rsp_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, hi;
        rst = 1'b1; t_valid = 1'b0; t_rsp_ready = 1'b0; cur = 0; t_drv = 1'b1;
        t_periph = '0; t_reg = '0; t_rw = 1'b1; t_wdata = '0;
        t_rd_val = 32'h0000ABCD; t_size = 3'd2; exp_sel = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", m.ready, 0);
        chk("rst_rsp_valid", m.valid, 0);
        chk("rst_rdata", m.rdata, 0);
        chk("rst_size", m.size, 0);
        chk("rst_error", m.err, 0);
        chk("rst_reg_addr", m.ra, 0);
        chk("rst_rw", m.rw, 1);
        chk("rst_select", m.sel, 0);
        chk("rst_bus_released", m.bus, IdleVal);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_cmd_ready", m.ready, 1);

        // Write periph 5: phase-by-phase bus checks
        t_drv = 1'b0;
        issue(7'd5, 8'h12, 1'b0, 32'hDEADBEEF);
        push(32'h0, 3'd0, 1'b0);
        @(negedge clk);
        chk("wr_setup_ra", m.ra, 8'h12);
        chk("wr_setup_rw", m.rw, 0);
        chk("wr_setup_bus", m.bus, 32'hDEADBEEF);
        chk("wr_setup_sel", m.sel, 0);
        repeat (2) begin
            @(negedge clk);
            chk("wr_strobe_sel", m.sel, 128'd1 << 5);
            chk("wr_strobe_bus", m.bus, 32'hDEADBEEF);
        end
        @(negedge clk);
        chk("wr_hold_sel", m.sel, 0);
        chk("wr_hold_rw", m.rw, 0);
        chk("wr_hold_ra", m.ra, 8'h12);
        chk("wr_hold_bus", m.bus, 32'hDEADBEEF);
        @(negedge clk);
        chk("wr_resp_valid", m.valid, 1);
        chk("wr_resp_rw", m.rw, 1);
        chk("wr_resp_ra", m.ra, 8'h12);
        check_rsp();
        ack();

        // Read periph 127: DUT must never drive databus
        t_drv = 1'b1;
        issue(7'd127, 8'h03, 1'b1, 32'hFFFF0000);
        push(32'h0000ABCD, 3'd2, 1'b0);
        @(negedge clk);
        chk("rd_setup_bus", m.bus, IdleVal);
        chk("rd_setup_rw", m.rw, 1);
        chk("rd_setup_ra", m.ra, 8'h03);
        @(negedge clk);
        chk("rd_strobe_sel", m.sel, 128'd1 << 127);
        chk("rd_strobe_bus", m.bus, 32'h0000ABCD);
        wait_rsp(10, n, hi);
        chk("rd_remaining_latency", n, 3);
        check_rsp();
        ack();

        // Back-to-back: second command waits for the response handshake
        t_drv = 1'b0;
        issue(7'd2, 8'h40, 1'b0, 32'hCAFEF00D);
        push(32'h0, 3'd0, 1'b0);
        t_periph = 7'd3; t_reg = 8'h41; t_rw = 1'b1; t_wdata = 32'h0; t_valid = 1'b1;
        wait_rsp(10, n, hi);
        chk("b2b_a_latency", n, 5);
        chk("b2b_a_strobe_len", hi, 2);
        repeat (5) begin
            @(negedge clk);
            chk("b2b_stall_valid", m.valid, 1);
            chk("b2b_stall_ready", m.ready, 0);
            chk("b2b_stall_rdata", m.rdata, 0);
            chk("b2b_stall_err", m.err, 0);
        end
        check_rsp();
        ack();
        t_drv = 1'b1;
        exp_sel = 128'd1 << 3;
        push(32'h0000ABCD, 3'd2, 1'b0);
        @(negedge clk);
        chk("b2b_ready_after_ack", m.ready, 1);
        @(posedge clk); #1;
        t_valid = 1'b0;
        wait_rsp(10, n, hi);
        chk("b2b_b_latency", n, 5);
        check_rsp();
        ack();

        // Reset in the middle of STROBE
        t_drv = 1'b0;
        issue(7'd9, 8'h22, 1'b0, 32'h12345678);
        @(negedge clk);
        @(negedge clk);
        chk("mid_strobe_sel", m.sel, 128'd1 << 9);
        rst = 1'b1; t_drv = 1'b1;
        #1;
        chk("rst_async_select", m.sel, 0);
        chk("rst_async_bus", m.bus, IdleVal);
        chk("rst_async_ready", m.ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_no_rsp", m.valid, 0);
            chk("rst_idle_ready", m.ready, 1);
        end
        t_drv = 1'b0;
        issue(7'd0, 8'hFF, 1'b0, 32'h1);
        push(32'h0, 3'd0, 1'b0);
        wait_rsp(10, n, hi);
        chk("post_rst_latency", n, 5);
        chk("post_rst_strobe_len", hi, 2);
        check_rsp();
        ack();

        // NUM_PERIPH=16: invalid, last valid, first invalid
        cur = 1; t_drv = 1'b1;
        issue(7'd20, 8'h05, 1'b1, 32'h0);
        push(32'h0, 3'd0, 1'b1);
        wait_rsp(10, n, hi);
        chk("err20_latency", n, 1);
        chk("err20_no_select", hi, 0);
        check_rsp();
        ack();
        issue(7'd15, 8'h06, 1'b1, 32'h0);
        push(32'h0000ABCD, 3'd2, 1'b0);
        wait_rsp(10, n, hi);
        chk("p15_latency", n, 5);
        chk("p15_strobe_len", hi, 2);
        check_rsp();
        ack();
        issue(7'd16, 8'h07, 1'b0, 32'h55);
        push(32'h0, 3'd0, 1'b1);
        wait_rsp(10, n, hi);
        chk("err16_latency", n, 1);
        check_rsp();
        ack();

        // SETUP=3, STROBE=1, HOLD=2
        cur = 2; t_drv = 1'b0;
        issue(7'd64, 8'h07, 1'b0, 32'hA5A5A5A5);
        push(32'h0, 3'd0, 1'b0);
        wait_rsp(20, n, hi);
        chk("s3t1h2_latency", n, 7);
        chk("s3t1h2_strobe_len", hi, 1);
        check_rsp();
        ack();

        chk("sb_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
